// File: rtl/vga_mon_pkg.sv
// Shared constants for the VGA sync monitor: lock FSM encodings, error bit indices and
// the default counter width.
package vga_mon_pkg;

    localparam int unsigned CNT_W_DEF = 12;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StTrain  = 2'd1;
    localparam logic [1:0] StLocked = 2'd2;

    localparam int unsigned ERR_LINE  = 0;
    localparam int unsigned ERR_HSW   = 1;
    localparam int unsigned ERR_FRAME = 2;
    localparam int unsigned ERR_VSW   = 3;

endpackage

// File: rtl/vga_mon_edge.sv
// Two-flop input register for one sync line; reports the registered level and the
// active-going (rise) and inactive-going (fall) edges relative to polarity POL.
module vga_mon_edge #(
    parameter logic POL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic lvl_q_o,
    output logic rise_o,
    output logic fall_o
);

    logic lvl_q;
    logic lvl_qq;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lvl_q  <= 1'b0;
            lvl_qq <= 1'b0;
        end else begin
            lvl_q  <= sig_i;
            lvl_qq <= lvl_q;
        end
    end

    assign lvl_q_o = lvl_q;
    assign rise_o  = (lvl_q == POL) && (lvl_qq != POL);
    assign fall_o  = (lvl_q != POL) && (lvl_qq == POL);

endmodule

// File: rtl/vga_sync_monitor.sv
// Checks VGA hs/vs timing against the configured geometry, keeps a lock FSM and sticky errors.
// Define VGA_MON_CHECKSUM_EN to build the per-frame pixel checksum; otherwise frame_sum_o is 0.
module vga_sync_monitor
    import vga_mon_pkg::*;
#(
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned V_SYNC  = 2,
    parameter logic        HS_POL  = 1'b0,
    parameter logic        VS_POL  = 1'b0,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hs_i,
    input  logic             vs_i,
    input  logic [3:0]       r_i,
    input  logic [3:0]       g_i,
    input  logic [3:0]       b_i,
    input  logic             clr_err_i,
    output logic             locked_o,
    output logic             frame_done_o,
    output logic [3:0]       err_o,
    output logic [CNT_W-1:0] line_len_o,
    output logic [CNT_W-1:0] frame_lines_o,
    output logic [15:0]      frame_sum_o
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] HTot   = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] HSync  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VTot   = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] VSync  = CNT_W'(V_SYNC);

    logic hs_lvl_q, hs_det, hs_fall;
    logic vs_lvl_q, vs_det, vs_fall;
    logic hs_act, vs_act;

    vga_mon_edge #(.POL(HS_POL)) u_hs_edge (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .sig_i   (hs_i),
        .lvl_q_o (hs_lvl_q),
        .rise_o  (hs_det),
        .fall_o  (hs_fall)
    );

    vga_mon_edge #(.POL(VS_POL)) u_vs_edge (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .sig_i   (vs_i),
        .lvl_q_o (vs_lvl_q),
        .rise_o  (vs_det),
        .fall_o  (vs_fall)
    );

    assign hs_act = (hs_lvl_q == HS_POL);
    assign vs_act = (vs_lvl_q == VS_POL);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] hpw_q, hpw_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] vpw_q, vpw_d;
    logic [CNT_W-1:0] line_len_q, line_len_d;
    logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
    logic             h_valid_q, h_valid_d;
    logic             v_valid_q, v_valid_d;
    logic [3:0]       err_q, err_d;
    logic [3:0]       err_ev;
    logic             any_ev;
    logic             hs_lost;
    logic             frame_err_q, frame_err_d;
    logic             frame_done_q, frame_done_d;
    logic [1:0]       state_q, state_d;

    always_comb begin
        h_cnt_d = h_cnt_q;
        if (hs_det) begin
            h_cnt_d = CntOne;
        end else if (h_cnt_q != CntMax) begin
            h_cnt_d = h_cnt_q + CntOne;
        end
        // Fires once, on the cycle the line counter reaches saturation.
        hs_lost = !hs_det && (h_cnt_q == CntMax - CntOne);

        hpw_d = hpw_q;
        if (hs_det) begin
            hpw_d = CntOne;
        end else if (hs_act && hpw_q != CntMax) begin
            hpw_d = hpw_q + CntOne;
        end

        // A coincident hs edge is line 1 of the new frame.
        v_cnt_d = v_cnt_q;
        vpw_d   = vpw_q;
        if (vs_det) begin
            v_cnt_d = CNT_W'(hs_det);
            vpw_d   = CNT_W'(hs_det);
        end else if (hs_det) begin
            if (v_cnt_q != CntMax) begin
                v_cnt_d = v_cnt_q + CntOne;
            end
            if (vs_act && vpw_q != CntMax) begin
                vpw_d = vpw_q + CntOne;
            end
        end

        h_valid_d     = h_valid_q | hs_det;
        v_valid_d     = v_valid_q | vs_det;
        line_len_d    = (hs_det && h_valid_q) ? h_cnt_q : line_len_q;
        frame_lines_d = (vs_det && v_valid_q) ? v_cnt_q : frame_lines_q;

        err_ev            = 4'b0000;
        err_ev[ERR_LINE]  = (hs_det && h_valid_q && h_cnt_q != HTot) || hs_lost;
        err_ev[ERR_HSW]   = hs_fall && h_valid_q && hpw_q != HSync;
        err_ev[ERR_FRAME] = vs_det && v_valid_q && v_cnt_q != VTot;
        err_ev[ERR_VSW]   = vs_fall && v_valid_q && vpw_q != VSync;
        any_ev            = |err_ev;

        err_d        = (clr_err_i ? 4'b0000 : err_q) | err_ev;
        frame_done_d = vs_det && v_valid_q;
        frame_err_d  = vs_det ? 1'b0 : (frame_err_q | any_ev);
    end

    always_comb begin
        state_d = state_q;
        if (hs_lost) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (vs_det) state_d = StTrain;
                end
                StTrain: begin
                    if (vs_det && !frame_err_q && !any_ev) state_d = StLocked;
                end
                StLocked: begin
                    if (any_ev) state_d = StTrain;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt_q       <= '0;
            hpw_q         <= '0;
            v_cnt_q       <= '0;
            vpw_q         <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            h_valid_q     <= 1'b0;
            v_valid_q     <= 1'b0;
            err_q         <= 4'b0000;
            frame_err_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            state_q       <= StIdle;
        end else begin
            h_cnt_q       <= h_cnt_d;
            hpw_q         <= hpw_d;
            v_cnt_q       <= v_cnt_d;
            vpw_q         <= vpw_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            h_valid_q     <= h_valid_d;
            v_valid_q     <= v_valid_d;
            err_q         <= err_d;
            frame_err_q   <= frame_err_d;
            frame_done_q  <= frame_done_d;
            state_q       <= state_d;
        end
    end

`ifdef VGA_MON_CHECKSUM_EN
    logic [3:0]  r_q, g_q, b_q;
    logic [15:0] pix;
    logic [15:0] acc_q, acc_d;
    logic [15:0] frame_sum_q, frame_sum_d;

    always_comb begin
        pix         = {4'b0000, r_q, g_q, b_q};
        // The detect cycle's pixel opens the new frame's sum.
        acc_d       = vs_det ? pix : acc_q + pix;
        frame_sum_d = vs_det ? acc_q : frame_sum_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q         <= 4'h0;
            g_q         <= 4'h0;
            b_q         <= 4'h0;
            acc_q       <= 16'h0000;
            frame_sum_q <= 16'h0000;
        end else begin
            r_q         <= r_i;
            g_q         <= g_i;
            b_q         <= b_i;
            acc_q       <= acc_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum_o = frame_sum_q;
`else
    logic unused_rgb;
    assign unused_rgb  = ^{r_i, g_i, b_i};
    assign frame_sum_o = 16'h0000;
`endif

    assign locked_o      = (state_q == StLocked);
    assign frame_done_o  = frame_done_q;
    assign err_o         = err_q;
    assign line_len_o    = line_len_q;
    assign frame_lines_o = frame_lines_q;

endmodule
